// File: rtl/alu_issue_wb.sv
// Issue/writeback controller for the execute ALU: decodes, issues operands
// from a local register file into a registered EX stage and writes results back.
module alu_issue_wb #(
    parameter int unsigned NREGS = 16,
    parameter int unsigned DW    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [4:0]               instr_op,
    input  logic [$clog2(NREGS)-1:0] instr_rd,
    input  logic [$clog2(NREGS)-1:0] instr_ra,
    input  logic [$clog2(NREGS)-1:0] instr_rb,
    output logic [4:0]               aluOp,
    output logic [DW-1:0]            srcA,
    output logic [DW-1:0]            srcB,
    input  logic [2*DW-1:0]          result,
    output logic                     wb_valid,
    output logic [$clog2(NREGS)-1:0] wb_rd,
    output logic [DW-1:0]            wb_data,
    output logic                     wb_ovf,
    output logic                     err_illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_data
);

    localparam int unsigned AW  = $clog2(NREGS);
    localparam int unsigned OPW = 5;

    localparam logic [OPW-1:0] OP_NOP   = 5'b00000;
    localparam logic [OPW-1:0] OP_PASSB = 5'b00001;
    localparam logic [OPW-1:0] OP_INC   = 5'b00100;

    logic [DW-1:0] regs [NREGS];

    logic          ex_wr;
    logic [AW-1:0] ex_rd;

    logic op_wr_c;
    logic op_illegal_c;
    logic hazard_c;
    logic accept_c;

    // Decode and RAW check against the single in-flight writer; the regfile
    // is updated at the EX edge, so a one-cycle stall replaces any bypass.
    always_comb begin
        op_wr_c      = (instr_op == OP_PASSB) || (instr_op == OP_INC);
        op_illegal_c = !op_wr_c && (instr_op != OP_NOP);
        hazard_c     = ex_wr && ((instr_ra == ex_rd) || (instr_rb == ex_rd));
    end

    assign instr_ready = !rst && !hazard_c;
    assign accept_c    = instr_valid && instr_ready;
    assign dbg_data    = regs[dbg_addr];

    // EX stage: load the accepted instruction or a zero bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            aluOp       <= '0;
            srcA        <= '0;
            srcB        <= '0;
            ex_wr       <= 1'b0;
            ex_rd       <= '0;
            err_illegal <= 1'b0;
        end else if (accept_c) begin
            aluOp       <= op_illegal_c ? OPW'(0) : instr_op;
            srcA        <= regs[instr_ra];
            srcB        <= regs[instr_rb];
            ex_wr       <= op_wr_c;
            ex_rd       <= instr_rd;
            err_illegal <= op_illegal_c;
        end else begin
            aluOp       <= '0;
            srcA        <= '0;
            srcB        <= '0;
            ex_wr       <= 1'b0;
            err_illegal <= 1'b0;
        end
    end

    // Writeback: low byte goes to the regfile, high byte only raises wb_ovf
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            wb_valid <= 1'b0;
            wb_rd    <= '0;
            wb_data  <= '0;
            wb_ovf   <= 1'b0;
        end else if (ex_wr) begin
            regs[ex_rd] <= result[DW-1:0];
            wb_valid    <= 1'b1;
            wb_rd       <= ex_rd;
            wb_data     <= result[DW-1:0];
            wb_ovf      <= |result[2*DW-1:DW];
        end else begin
            wb_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: stub ALU, transaction-level reference model checked
// every cycle, directed scenarios with literal expectations, then random traffic.
module tb_alu_issue_wb;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  instr_op;
    logic [3:0]  instr_rd;
    logic [3:0]  instr_ra;
    logic [3:0]  instr_rb;
    logic [4:0]  aluOp;
    logic [7:0]  srcA;
    logic [7:0]  srcB;
    logic [15:0] result;
    logic        wb_valid;
    logic [3:0]  wb_rd;
    logic [7:0]  wb_data;
    logic        wb_ovf;
    logic        err_illegal;
    logic [3:0]  dbg_addr;
    logic [7:0]  dbg_data;

    alu_issue_wb #(.NREGS(16), .DW(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_rd    (instr_rd),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .aluOp       (aluOp),
        .srcA        (srcA),
        .srcB        (srcB),
        .result      (result),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_ovf      (wb_ovf),
        .err_illegal (err_illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Stub ALU; pass-B carries srcA in the upper byte so overflow flagging is exercised
    always_comb begin
        case (aluOp)
            5'b00001: result = {srcA, srcB};
            5'b00100: result = {8'h00, 8'(srcA + 8'd1)};
            default:  result = 16'h0000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int stall_cnt = 0;
    logic [11:0] wb_log [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: architectural registers plus the one pending write
    logic [7:0] m_regs [16] = '{default: 8'h00};
    logic       m_ex_wr   = 1'b0;
    logic [3:0] m_ex_rd   = 4'h0;
    logic [7:0] m_ex_val  = 8'h00;
    logic [7:0] m_ex_hi   = 8'h00;
    logic [4:0] m_aluop   = 5'h00;
    logic [7:0] m_srca    = 8'h00;
    logic [7:0] m_srcb    = 8'h00;
    logic       m_err     = 1'b0;
    logic       m_wb_valid = 1'b0;
    logic [3:0] m_wb_rd   = 4'h0;
    logic [7:0] m_wb_data = 8'h00;
    logic       m_wb_ovf  = 1'b0;
    logic       m_ready;
    logic       m_legal_wr;
    logic       m_illegal;
    logic [7:0] a_val;
    logic [7:0] b_val;

    always @(negedge clk) begin
        m_ready = !rst && !(m_ex_wr && ((instr_ra == m_ex_rd) || (instr_rb == m_ex_rd)));
        check("instr_ready", 32'(instr_ready), 32'(m_ready));
        check("aluOp",       32'(aluOp),       32'(m_aluop));
        check("srcA",        32'(srcA),        32'(m_srca));
        check("srcB",        32'(srcB),        32'(m_srcb));
        check("err_illegal", 32'(err_illegal), 32'(m_err));
        check("wb_valid",    32'(wb_valid),    32'(m_wb_valid));
        if (m_wb_valid) begin
            check("wb_rd",   32'(wb_rd),   32'(m_wb_rd));
            check("wb_data", 32'(wb_data), 32'(m_wb_data));
            check("wb_ovf",  32'(wb_ovf),  32'(m_wb_ovf));
        end
        check("dbg_data", 32'(dbg_data), 32'(m_regs[dbg_addr]));
        if (wb_valid) wb_log.push_back({wb_rd, wb_data});

        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
            m_ex_wr = 1'b0; m_aluop = 5'h00; m_srca = 8'h00; m_srcb = 8'h00; m_err = 1'b0;
            m_wb_valid = 1'b0; m_wb_rd = 4'h0; m_wb_data = 8'h00; m_wb_ovf = 1'b0;
        end else begin
            a_val = m_regs[instr_ra];
            b_val = m_regs[instr_rb];
            if (m_ex_wr) begin
                m_regs[m_ex_rd] = m_ex_val;
                m_wb_valid = 1'b1;
                m_wb_rd    = m_ex_rd;
                m_wb_data  = m_ex_val;
                m_wb_ovf   = (m_ex_hi != 8'h00);
            end else begin
                m_wb_valid = 1'b0;
            end
            if (instr_valid && m_ready) begin
                m_legal_wr = (instr_op == 5'd1) || (instr_op == 5'd4);
                m_illegal  = !m_legal_wr && (instr_op != 5'd0);
                m_aluop  = m_illegal ? 5'd0 : instr_op;
                m_srca   = a_val;
                m_srcb   = b_val;
                m_ex_wr  = m_legal_wr;
                m_ex_rd  = instr_rd;
                m_ex_val = (instr_op == 5'd1) ? b_val : 8'(a_val + 8'd1);
                m_ex_hi  = (instr_op == 5'd1) ? a_val : 8'h00;
                m_err    = m_illegal;
            end else begin
                m_aluop = 5'd0; m_srca = 8'h00; m_srcb = 8'h00; m_ex_wr = 1'b0; m_err = 1'b0;
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Called and returns at posedge+1; holds valid until the transfer edge
    task automatic issue(input logic [4:0] op, input logic [3:0] rd,
                         input logic [3:0] ra, input logic [3:0] rb);
        int n;
        n = 0;
        instr_valid = 1'b1;
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            stall_cnt++;
            n++;
            @(negedge clk);
        end
        check("issue_accept", 32'(instr_ready), 32'd1);
        sync();
        instr_valid = 1'b0;
    endtask

    task automatic dbg_expect(input string name, input logic [3:0] addr, input logic [7:0] val);
        dbg_addr = addr;
        @(negedge clk);
        check(name, 32'(dbg_data), 32'(val));
        sync();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int r;

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_op = 5'd0;
        instr_rd = 4'd0; instr_ra = 4'd0; instr_rb = 4'd0; dbg_addr = 4'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("ready_in_reset", 32'(instr_ready), 32'd0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(instr_ready), 32'd1);
        check("wb_valid_after_reset", 32'(wb_valid), 32'd0);
        sync();
        for (int i = 0; i < 16; i++) dbg_expect("reset_reg", 4'(i), 8'h00);

        // RAW chain on r3: one stall between each pair
        stall_cnt = 0; wb_log.delete();
        repeat (4) issue(5'b00100, 4'd3, 4'd3, 4'd3);
        repeat (3) sync();
        check("raw_stalls", 32'(stall_cnt), 32'd3);
        check("raw_wb_count", 32'(wb_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wb_log.size(); i++)
            check("raw_wb_seq", 32'(wb_log[i]), 32'(12'h300 + 12'(i + 1)));
        dbg_expect("r3_final", 4'd3, 8'h04);

        // Independent back-to-back: no stall
        stall_cnt = 0; wb_log.delete();
        issue(5'b00001, 4'd5, 4'd0, 4'd3);
        issue(5'b00100, 4'd6, 4'd1, 4'd0);
        repeat (3) sync();
        check("indep_stalls", 32'(stall_cnt), 32'd0);
        check("indep_wb_count", 32'(wb_log.size()), 32'd2);
        if (wb_log.size() == 2) begin
            check("indep_wb0", 32'(wb_log[0]), 32'h504);
            check("indep_wb1", 32'(wb_log[1]), 32'h601);
        end
        dbg_expect("r5", 4'd5, 8'h04);
        dbg_expect("r6", 4'd6, 8'h01);

        // Illegal opcode: nop issued, error pulse, r2 unchanged
        issue(5'b00100, 4'd2, 4'd0, 4'd0);
        repeat (2) sync();
        wb_log.delete();
        issue(5'b01111, 4'd2, 4'd2, 4'd2);
        @(negedge clk);
        check("illegal_err", 32'(err_illegal), 32'd1);
        check("illegal_aluop", 32'(aluOp), 32'd0);
        sync();
        @(negedge clk);
        check("illegal_err_clear", 32'(err_illegal), 32'd0);
        sync();
        repeat (2) sync();
        check("illegal_no_wb", 32'(wb_log.size()), 32'd0);
        dbg_expect("r2_unchanged", 4'd2, 8'h01);

        // Reset during EX drops the write
        issue(5'b00100, 4'd7, 4'd7, 4'd7);
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_wb_valid", 32'(wb_valid), 32'd0);
        check("rstmid_aluop", 32'(aluOp), 32'd0);
        check("rstmid_srcA", 32'(srcA), 32'd0);
        check("rstmid_wb_rd", 32'(wb_rd), 32'd0);
        check("rstmid_wb_data", 32'(wb_data), 32'd0);
        check("rstmid_err", 32'(err_illegal), 32'd0);
        sync();
        dbg_expect("r7_after_rst", 4'd7, 8'h00);
        dbg_expect("r3_after_rst", 4'd3, 8'h00);

        // Drive r9 to 8'hFF, check overflow flag, then wrap
        repeat (255) issue(5'b00100, 4'd9, 4'd9, 4'd9);
        repeat (2) sync();
        dbg_expect("r9_ff", 4'd9, 8'hFF);
        issue(5'b00001, 4'd10, 4'd9, 4'd9);
        sync();
        @(negedge clk);
        check("ovf_wb_valid", 32'(wb_valid), 32'd1);
        check("ovf_wb_data", 32'(wb_data), 32'hFF);
        check("ovf_flag", 32'(wb_ovf), 32'd1);
        sync();
        issue(5'b00100, 4'd9, 4'd9, 4'd9);
        sync();
        @(negedge clk);
        check("wrap_wb_rd", 32'(wb_rd), 32'd9);
        check("wrap_wb_data", 32'(wb_data), 32'h00);
        check("wrap_wb_ovf", 32'(wb_ovf), 32'd0);
        sync();
        dbg_expect("r9_wrapped", 4'd9, 8'h00);

        // Random traffic, biased toward a few registers to provoke hazards
        for (int c = 0; c < 2500; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            instr_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 7);
            case (r)
                0:       instr_op = 5'd0;
                1, 2, 6: instr_op = 5'd1;
                5:       instr_op = 5'($urandom);
                default: instr_op = 5'd4;
            endcase
            instr_rd = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            instr_ra = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            instr_rb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            dbg_addr = 4'($urandom);
            sync();
        end
        rst = 1'b0; instr_valid = 1'b0;
        repeat (5) sync();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
